// File: rtl/nco_sweep_pkg.sv
// -----------------------------------------------------------------------------
// nco_sweep_pkg
// Shared types and default widths for the NCO frequency-sweep controller.
//   state_t : controller FSM states (IDLE / SWEEP / FINISH)
//   dir_t   : sweep direction (UP / DOWN)
//   PHASE_W_DEF / DWELL_W_DEF : default phase-increment and dwell widths
// -----------------------------------------------------------------------------
package nco_sweep_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Opposite direction, used when a triangle sweep turns around.
  function automatic dir_t dir_flip(input dir_t d);
    dir_flip = (d == DIR_UP) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/nco_sweep_step.sv
// -----------------------------------------------------------------------------
// nco_sweep_step
// Combinational next-value calculator for one sweep leg.
//   cur      : current phase increment
//   step     : unsigned step magnitude
//   stop     : leg endpoint (value is never allowed past it)
//   dir      : leg direction
//   next_val : cur +/- step, clamped to stop
//   at_stop  : the leg is finished (cur already at stop, or step is zero)
// The arithmetic is one bit wider than the phase so that a carry out of the
// top or a borrow through zero is detected and clamped rather than wrapping.
// -----------------------------------------------------------------------------
module nco_sweep_step
  import nco_sweep_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic [PHASE_W-1:0] cur,
  input  logic [PHASE_W-1:0] step,
  input  logic [PHASE_W-1:0] stop,
  input  dir_t               dir,
  output logic [PHASE_W-1:0] next_val,
  output logic               at_stop
);

  logic [PHASE_W:0] sum_s;
  logic [PHASE_W:0] diff_s;

  // Widened add/subtract and clamp to the leg endpoint.
  always_comb begin
    sum_s    = {1'b0, cur} + {1'b0, step};
    diff_s   = {1'b0, cur} - {1'b0, step};
    next_val = stop;
    if (dir == DIR_UP) begin
      if (sum_s[PHASE_W] || (sum_s[PHASE_W-1:0] > stop)) begin
        next_val = stop;
      end else begin
        next_val = sum_s[PHASE_W-1:0];
      end
    end else begin
      if (diff_s[PHASE_W] || (diff_s[PHASE_W-1:0] < stop)) begin
        next_val = stop;
      end else begin
        next_val = diff_s[PHASE_W-1:0];
      end
    end
    // A zero step can never reach a distinct stop, so it ends the leg after
    // one dwell period just like an equal start/stop pair.
    at_stop = (cur == stop) || (step == {PHASE_W{1'b0}});
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
// Linear frequency-sweep sequencer feeding the CORDIC NCO phase increment.
// Steps phase_inc_o from start_inc to stop_inc, holding each value for
// dwell+1 valid cycles, single-shot or continuous.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-low reset
//   start_i      start pulse, honoured only in IDLE
//   abort_i      terminate sweep immediately (wins over start_i in IDLE)
//   cont_i       1 = continuous, 0 = single-shot (latched at start)
//   start_inc_i  first phase increment (latched at start)
//   stop_inc_i   final phase increment (latched at start)
//   step_i       unsigned step magnitude (latched at start)
//   dwell_i      hold length minus one (latched at start)
//   phase_inc_o  phase increment to NCO
//   val_o        phase_inc_o is a live sample
//   busy_o       controller is outside IDLE
//   done_o       one-cycle pulse at the end of a single-shot sweep
//   wrap_o       one-cycle pulse on the first sample after a restart/reversal
//
// Build option:
//   NCO_SWEEP_TRIANGLE_EN - continuous mode reverses at each endpoint
//                           (triangle) instead of jumping back (sawtooth).
// -----------------------------------------------------------------------------
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               cont_i,
  input  logic [PHASE_W-1:0] start_inc_i,
  input  logic [PHASE_W-1:0] stop_inc_i,
  input  logic [PHASE_W-1:0] step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [PHASE_W-1:0] phase_inc_o,
  output logic               val_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               wrap_o
);

  state_t             state_r,     state_nx_s;
  logic [PHASE_W-1:0] phase_inc_r, phase_nx_s;
  logic               val_r,       val_nx_s;
  logic               busy_r,      busy_nx_s;
  logic               done_r,      done_nx_s;
  logic               wrap_r,      wrap_nx_s;
  logic [PHASE_W-1:0] start_r,     start_nx_s;
  logic [PHASE_W-1:0] stop_r,      stop_nx_s;
  logic [PHASE_W-1:0] step_r,      step_nx_s;
  logic [DWELL_W-1:0] dwell_r,     dwell_nx_s;
  logic               cont_r,      cont_nx_s;
  logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_nx_s;
  // leg_r = 1 while a triangle sweep runs back from stop toward start.
  logic               leg_r,       leg_nx_s;

  dir_t               dir0_s;
  dir_t               dir_s;
  logic [PHASE_W-1:0] target_s;
  logic [PHASE_W-1:0] calc_next_s;
  logic               at_stop_s;

  // Leg direction and endpoint derived from the latched configuration.
  always_comb begin
    dir0_s = (stop_r >= start_r) ? DIR_UP : DIR_DOWN;
    if (leg_r) begin
      dir_s    = dir_flip(dir0_s);
      target_s = start_r;
    end else begin
      dir_s    = dir0_s;
      target_s = stop_r;
    end
  end

  nco_sweep_step #(.PHASE_W(PHASE_W)) u_step (
    .cur      (phase_inc_r),
    .step     (step_r),
    .stop     (target_s),
    .dir      (dir_s),
    .next_val (calc_next_s),
    .at_stop  (at_stop_s)
  );

`ifdef NCO_SWEEP_TRIANGLE_EN
  // First sample of the opposite leg, taken straight from the turning point.
  logic [PHASE_W-1:0] rev_target_s;
  logic [PHASE_W-1:0] rev_next_s;
  logic               rev_at_stop_s;

  assign rev_target_s = leg_r ? stop_r : start_r;

  nco_sweep_step #(.PHASE_W(PHASE_W)) u_step_rev (
    .cur      (phase_inc_r),
    .step     (step_r),
    .stop     (rev_target_s),
    .dir      (dir_flip(dir_s)),
    .next_val (rev_next_s),
    .at_stop  (rev_at_stop_s)
  );
`endif

  // Next-state and next-output logic of the sweep FSM.
  always_comb begin
    state_nx_s     = state_r;
    phase_nx_s     = phase_inc_r;
    val_nx_s       = 1'b0;
    busy_nx_s      = busy_r;
    done_nx_s      = 1'b0;
    wrap_nx_s      = 1'b0;
    start_nx_s     = start_r;
    stop_nx_s      = stop_r;
    step_nx_s      = step_r;
    dwell_nx_s     = dwell_r;
    cont_nx_s      = cont_r;
    dwell_cnt_nx_s = dwell_cnt_r;
    leg_nx_s       = leg_r;

    case (state_r)
      ST_IDLE: begin
        busy_nx_s = 1'b0;
        if (start_i && !abort_i) begin
          start_nx_s     = start_inc_i;
          stop_nx_s      = stop_inc_i;
          step_nx_s      = step_i;
          dwell_nx_s     = dwell_i;
          cont_nx_s      = cont_i;
          state_nx_s     = ST_SWEEP;
          phase_nx_s     = start_inc_i;
          val_nx_s       = 1'b1;
          busy_nx_s      = 1'b1;
          dwell_cnt_nx_s = {DWELL_W{1'b0}};
          leg_nx_s       = 1'b0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_SWEEP: begin
        if (abort_i) begin
          state_nx_s     = ST_IDLE;
          busy_nx_s      = 1'b0;
          dwell_cnt_nx_s = {DWELL_W{1'b0}};
        end else if (dwell_cnt_r != dwell_r) begin
          dwell_cnt_nx_s = dwell_cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
          val_nx_s       = 1'b1;
        end else begin
          dwell_cnt_nx_s = {DWELL_W{1'b0}};
          if (!at_stop_s) begin
            phase_nx_s = calc_next_s;
            val_nx_s   = 1'b1;
          end else if (!cont_r) begin
            state_nx_s = ST_FINISH;
            done_nx_s  = 1'b1;
          end else begin
            val_nx_s  = 1'b1;
            wrap_nx_s = 1'b1;
`ifdef NCO_SWEEP_TRIANGLE_EN
            leg_nx_s   = ~leg_r;
            phase_nx_s = rev_next_s;
`else
            phase_nx_s = start_r;
`endif
          end
        end
      end

      ST_FINISH: begin
        state_nx_s = ST_IDLE;
        busy_nx_s  = 1'b0;
      end

      default: begin
        state_nx_s = ST_IDLE;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State, configuration and registered-output flops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      phase_inc_r <= {PHASE_W{1'b0}};
      val_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wrap_r      <= 1'b0;
      start_r     <= {PHASE_W{1'b0}};
      stop_r      <= {PHASE_W{1'b0}};
      step_r      <= {PHASE_W{1'b0}};
      dwell_r     <= {DWELL_W{1'b0}};
      cont_r      <= 1'b0;
      dwell_cnt_r <= {DWELL_W{1'b0}};
      leg_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      phase_inc_r <= phase_nx_s;
      val_r       <= val_nx_s;
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      wrap_r      <= wrap_nx_s;
      start_r     <= start_nx_s;
      stop_r      <= stop_nx_s;
      step_r      <= step_nx_s;
      dwell_r     <= dwell_nx_s;
      cont_r      <= cont_nx_s;
      dwell_cnt_r <= dwell_cnt_nx_s;
      leg_r       <= leg_nx_s;
    end
  end

  assign phase_inc_o = phase_inc_r;
  assign val_o       = val_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign wrap_o      = wrap_r;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nco_sweep_ctrl
// Directed bench for nco_sweep_ctrl: a table of single-shot sweeps with
// hand-computed sample sequences, plus hand-written continuous, abort,
// handshake and reset sequences. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_nco_sweep_ctrl;

  localparam int PW = 16;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i, abort_i, cont_i;
  logic [PW-1:0] start_inc_i, stop_inc_i, step_i;
  logic [DW-1:0] dwell_i;
  logic [PW-1:0] phase_inc_o;
  logic          val_o, busy_o, done_o, wrap_o;

  nco_sweep_ctrl #(.PHASE_W(PW), .DWELL_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .cont_i      (cont_i),
    .start_inc_i (start_inc_i),
    .stop_inc_i  (stop_inc_i),
    .step_i      (step_i),
    .dwell_i     (dwell_i),
    .phase_inc_o (phase_inc_o),
    .val_o       (val_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .wrap_o      (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [PW-1:0] s_inc;
    logic [PW-1:0] p_inc;
    logic [PW-1:0] stp;
    logic [DW-1:0] dwl;
    logic [7:0]    base;
    logic [7:0]    n;
  } vec_t;

  vec_t          vecs [0:6];
  logic [PW-1:0] pool [0:31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Check one live sample cycle.
  task automatic chk_sample(input string name, input logic [PW-1:0] ph, input logic wr);
    chk({name, " phase"}, {16'h0000, phase_inc_o}, {16'h0000, ph});
    chk({name, " val"},  {31'd0, val_o},  32'd1);
    chk({name, " busy"}, {31'd0, busy_o}, 32'd1);
    chk({name, " wrap"}, {31'd0, wrap_o}, {31'd0, wr});
    chk({name, " done"}, {31'd0, done_o}, 32'd0);
  endtask

  task automatic start_sweep(input logic [PW-1:0] s, input logic [PW-1:0] p,
                             input logic [PW-1:0] st, input logic [DW-1:0] dw,
                             input logic c);
    @(negedge clk_i);
    start_inc_i = s; stop_inc_i = p; step_i = st; dwell_i = dw; cont_i = c;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  logic [PW-1:0] last_s;
  logic [PW-1:0] exp_a, exp_b, exp_c;

  initial begin
    rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; cont_i = 1'b0;
    start_inc_i = '0; stop_inc_i = '0; step_i = '0; dwell_i = '0;

    // Single-shot vectors: start, stop, step, dwell, pool base, sample count.
    vecs[0] = '{16'h0100, 16'h0130, 16'h0010, 16'd1, 8'd0,  8'd8};
    vecs[1] = '{16'h0100, 16'h0125, 16'h0010, 16'd0, 8'd8,  8'd4};
    vecs[2] = '{16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 8'd12, 8'd2};
    vecs[3] = '{16'h0200, 16'h01E0, 16'h0010, 16'd0, 8'd14, 8'd3};
    vecs[4] = '{16'h0200, 16'h01E0, 16'h0000, 16'd0, 8'd17, 8'd1};
    vecs[5] = '{16'h0150, 16'h0150, 16'h0010, 16'd1, 8'd18, 8'd2};
    vecs[6] = '{16'h0010, 16'h0005, 16'h0020, 16'd0, 8'd20, 8'd2};
    pool[0]  = 16'h0100; pool[1]  = 16'h0100; pool[2]  = 16'h0110; pool[3]  = 16'h0110;
    pool[4]  = 16'h0120; pool[5]  = 16'h0120; pool[6]  = 16'h0130; pool[7]  = 16'h0130;
    pool[8]  = 16'h0100; pool[9]  = 16'h0110; pool[10] = 16'h0120; pool[11] = 16'h0125;
    pool[12] = 16'hFFF0; pool[13] = 16'hFFFF;
    pool[14] = 16'h0200; pool[15] = 16'h01F0; pool[16] = 16'h01E0;
    pool[17] = 16'h0200;
    pool[18] = 16'h0150; pool[19] = 16'h0150;
    pool[20] = 16'h0010; pool[21] = 16'h0005;
    for (int i = 22; i < 32; i++) pool[i] = 16'h0000;

    // Reset state.
    #12;
    chk("reset phase", {16'h0000, phase_inc_o}, 32'd0);
    chk("reset val",   {31'd0, val_o},  32'd0);
    chk("reset busy",  {31'd0, busy_o}, 32'd0);
    chk("reset done",  {31'd0, done_o}, 32'd0);
    chk("reset wrap",  {31'd0, wrap_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Table of single-shot sweeps.
    for (int v = 0; v < 7; v++) begin
      start_sweep(vecs[v].s_inc, vecs[v].p_inc, vecs[v].stp, vecs[v].dwl, 1'b0);
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        last_s = pool[int'(vecs[v].base) + k];
        chk_sample($sformatf("vec%0d s%0d", v, k), last_s, 1'b0);
        @(negedge clk_i);
      end
      chk($sformatf("vec%0d finish val", v),  {31'd0, val_o},  32'd0);
      chk($sformatf("vec%0d finish done", v), {31'd0, done_o}, 32'd1);
      chk($sformatf("vec%0d finish busy", v), {31'd0, busy_o}, 32'd1);
      @(negedge clk_i);
      chk($sformatf("vec%0d idle busy", v),  {31'd0, busy_o}, 32'd0);
      chk($sformatf("vec%0d idle done", v),  {31'd0, done_o}, 32'd0);
      chk($sformatf("vec%0d hold phase", v), {16'h0000, phase_inc_o}, {16'h0000, last_s});
    end

    // Continuous sweep: restart (or reversal) with no gap, then abort.
`ifdef NCO_SWEEP_TRIANGLE_EN
    exp_a = 16'h0120; exp_b = 16'h0120; exp_c = 16'h0110;
`else
    exp_a = 16'h0100; exp_b = 16'h0100; exp_c = 16'h0110;
`endif
    start_sweep(16'h0100, 16'h0130, 16'h0010, 16'd1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk_sample($sformatf("cont s%0d", k), pool[k], 1'b0);
      @(negedge clk_i);
    end
    chk_sample("cont wrap s0", exp_a, 1'b1);
    @(negedge clk_i);
    chk_sample("cont wrap s1", exp_b, 1'b0);
    @(negedge clk_i);
    chk_sample("cont wrap s2", exp_c, 1'b0);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abort val",  {31'd0, val_o},  32'd0);
    chk("abort busy", {31'd0, busy_o}, 32'd0);
    chk("abort done", {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
    chk("abort later done", {31'd0, done_o}, 32'd0);
    chk("abort later val",  {31'd0, val_o},  32'd0);

`ifdef NCO_SWEEP_TRIANGLE_EN
    // Triangle turn-around at both endpoints.
    start_sweep(16'h0100, 16'h0120, 16'h0010, 16'd0, 1'b1);
    chk_sample("tri s0", 16'h0100, 1'b0); @(negedge clk_i);
    chk_sample("tri s1", 16'h0110, 1'b0); @(negedge clk_i);
    chk_sample("tri s2", 16'h0120, 1'b0); @(negedge clk_i);
    chk_sample("tri s3", 16'h0110, 1'b1); @(negedge clk_i);
    chk_sample("tri s4", 16'h0100, 1'b0); @(negedge clk_i);
    chk_sample("tri s5", 16'h0110, 1'b1); @(negedge clk_i);
    chk_sample("tri s6", 16'h0120, 1'b0);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("tri abort busy", {31'd0, busy_o}, 32'd0);
`endif

    // start_i during SWEEP is ignored.
    start_sweep(16'h0100, 16'h0130, 16'h0010, 16'd0, 1'b0);
    chk_sample("ign s0", 16'h0100, 1'b0);
    start_i = 1'b1; start_inc_i = 16'h0500; stop_inc_i = 16'h0600;
    @(negedge clk_i);
    start_i = 1'b0;
    chk_sample("ign s1", 16'h0110, 1'b0); @(negedge clk_i);
    chk_sample("ign s2", 16'h0120, 1'b0); @(negedge clk_i);
    chk_sample("ign s3", 16'h0130, 1'b0); @(negedge clk_i);
    chk("ign done", {31'd0, done_o}, 32'd1);
    @(negedge clk_i);

    // start_i with abort_i in IDLE: abort wins.
    @(negedge clk_i);
    start_inc_i = 16'h0100; stop_inc_i = 16'h0130; start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    chk("st+ab busy", {31'd0, busy_o}, 32'd0);
    chk("st+ab val",  {31'd0, val_o},  32'd0);
    @(negedge clk_i);
    chk("st+ab later busy", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset mid-sweep, then a fresh start.
    start_sweep(16'h0100, 16'h0130, 16'h0010, 16'd0, 1'b0);
    chk_sample("rst s0", 16'h0100, 1'b0); @(negedge clk_i);
    chk_sample("rst s1", 16'h0110, 1'b0);
    #2 rst_i = 1'b0;
    #1;
    chk("rst async phase", {16'h0000, phase_inc_o}, 32'd0);
    chk("rst async val",   {31'd0, val_o},  32'd0);
    chk("rst async busy",  {31'd0, busy_o}, 32'd0);
    chk("rst async done",  {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("rst held done", {31'd0, done_o}, 32'd0);
    start_sweep(16'h0300, 16'h0320, 16'h0010, 16'd0, 1'b0);
    chk_sample("rst restart s0", 16'h0300, 1'b0); @(negedge clk_i);
    chk_sample("rst restart s1", 16'h0310, 1'b0); @(negedge clk_i);
    chk_sample("rst restart s2", 16'h0320, 1'b0); @(negedge clk_i);
    chk("rst restart done", {31'd0, done_o}, 32'd1);
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
